seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
// Iterative shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops in the execute stage.
// Accepts one operation per valid/ready handshake and returns one XLEN-bit result per handshake.
// The per-cycle partial-product accumulate is a 2*XLEN ripple-carry adder built from full_adder cells.
// Multi-cycle, not pipelined: at most one operation is in flight.
// PARAMETERS
// XLEN  32  operand/result width; must be >= 2. The product is 2*XLEN bits wide.
// PORTS
// clk        in   1      clock; all state changes on the rising edge
// rst        in   1      synchronous reset, active-high
// in_valid   in   1      an operation is presented on op_a/op_b/funct
// in_ready   out  1      multiplier can accept an operation; 1 only in IDLE
// op_a       in   XLEN   multiplicand (rs1)
// op_b       in   XLEN   multiplier (rs2)
// funct      in   2      00 MUL (low half), 01 MULH (s*s, high), 10 MULHSU (s*u, high), 11 MULHU (u*u, high)
// out_valid  out  1      result is valid; 1 only in DONE
// out_ready  in   1      consumer accepts the result
// result     out  XLEN   selected half of the product
// busy       out  1      1 in RUN or DONE
// BEHAVIOUR
// Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, and all internal registers cleared.
// Reset takes priority over every other event, including in mid-RUN and in DONE: the in-flight op is dropped.
// FSM states: IDLE -> RUN -> FIX -> DONE -> IDLE.
// IDLE: in_ready=1. When in_valid is 1 on a rising edge, the block
//   - latches funct;
//   - computes sign flags: a is signed for funct 01/10; b is signed for funct 01 only;
//   - neg = sign(a) XOR sign(b), using only the operands that are signed;
//   - loads mcand = |a| and mplier = |b| as unsigned XLEN values (-2^(XLEN-1) maps to 2^(XLEN-1));
//   - clears acc[2*XLEN-1:0] and cnt, then goes to RUN.
// RUN: one iteration per cycle for exactly XLEN cycles.
//   - If mplier[0]=1, acc += mcand << cnt (2*XLEN-bit add). The carry out of bit 2*XLEN-1 is discarded.
//   - mplier >>= 1; cnt++.
//   - After the cycle with cnt==XLEN-1, go to FIX.
// FIX: if neg, acc = ~acc + 1 (modulo 2^(2*XLEN)). Then result = (funct==00) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN].
//   Go to DONE.
// DONE: out_valid=1, in_ready=0. result and out_valid stay stable until out_valid && out_ready on an edge,
//   then go to IDLE. A new op is never accepted in the same cycle as the result handshake.
// Latency: out_valid rises XLEN+2 cycles after the accept edge (34 for XLEN=32) when there is no backpressure.
// Throughput: with out_ready tied to 1, one op per XLEN+3 cycles.
// Outputs in_ready, out_valid and busy decode from state only, with no combinational path from any input.
// result is registered and holds its last value in IDLE.
// Multiply by 0: the block still runs all XLEN iterations, so latency does not depend on the data.
// in_valid while not in IDLE is ignored. Operand inputs are sampled only on the accept edge.
// TESTING
// 1. MUL 7 * 6 -> result=0x0000002A after 34 cycles; out_valid=1, in_ready=0 until the handshake.
// 2. MULH 0x80000000 * 0x80000000 -> 0x40000000.
//    MUL 0xFFFFFFFF * 0x00000003 -> 0xFFFFFFFD.
// 3. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
//    MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
//    MULH 0xFFFFFFFF * 0x00000001 -> 0xFFFFFFFF.
// 4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable and in_ready=0;
//    in_valid pulses are ignored; on out_ready=1 -> IDLE in 1 cycle.
// 5. Reset mid-operation: rst=1 at RUN cycle 15 -> next cycle IDLE, out_valid=0, result=0;
//    a following MUL 3 * 5 -> 0x0000000F.
// 6. Back-to-back: 100 random ops of all functs with out_ready=1 are compared against a 64-bit reference model.
//    Every op must take exactly 35 cycles from accept to the return to IDLE.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One op in flight; partial products accumulate through a ripple-carry chain of full_adder cells.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module seq_multiplier #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [1:0]      funct,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   localparam int PW = 2 * XLEN;
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [1:0]      funct_q, funct_d;
   logic            neg_q, neg_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_abs, b_abs;
   logic [PW-1:0]   add_a, add_b, sum, fixed;
   logic [PW-1:0]   carry;

   assign a_sgn = funct[0] ^ funct[1];
   assign b_sgn = (funct == 2'b01);
   assign a_neg = a_sgn & op_a[XLEN-1];
   assign b_neg = b_sgn & op_b[XLEN-1];
   assign a_abs = a_neg ? (~op_a + 1'b1) : op_a;
   assign b_abs = b_neg ? (~op_b + 1'b1) : op_b;

   // Shared adder: accumulates in RUN, forms the two's complement in FIX.
   assign carry[0] = 1'b0;
   for (genvar i = 0; i < PW; i++) begin : g_add
      if (i < PW - 1) begin : g_fa
         full_adder u_fa (
            .a (add_a[i]),
            .b (add_b[i]),
            .ci(carry[i]),
            .s (sum[i]),
            .co(carry[i+1])
         );
      end else begin : g_top
         // Carry out of the top bit is discarded, so only the sum is formed here.
         assign sum[i] = add_a[i] ^ add_b[i] ^ carry[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      funct_d  = funct_q;
      neg_d    = neg_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      add_a    = acc_q;
      add_b    = '0;
      fixed    = acc_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               funct_d  = funct;
               neg_d    = a_neg ^ b_neg;
               mcand_d  = {{XLEN{1'b0}}, a_abs};
               mplier_d = b_abs;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (mplier_q[0]) add_b = mcand_q;
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            add_a    = ~acc_q;
            add_b    = PW'(1);
            fixed    = neg_q ? sum : acc_q;
            acc_d    = fixed;
            result_d = (funct_q == 2'b00) ? fixed[XLEN-1:0] : fixed[PW-1:XLEN];
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         funct_q  <= '0;
         neg_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         funct_q  <= funct_d;
         neg_q    <= neg_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_RUN) || (state_q == S_FIX) || (state_q == S_DONE);
   assign result    = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: vector table, backpressure, mid-run reset and random back-to-back ops.

module tb_seq_multiplier;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a, op_b;
   logic [1:0]  funct;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  f;
      logic [31:0] exp;
   } vec_t;

   seq_multiplier #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op_a     (op_a),
      .op_b     (op_b),
      .funct    (funct),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Sign/zero-extend to 64 bits and multiply modulo 2^64.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] f);
      logic [63:0] ea, eb, p;
      ea = (f == 2'b01 || f == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (f == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (f == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Called at a negedge while IDLE with out_ready=1; returns at the negedge back in IDLE.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                         input logic [31:0] exp, input string name);
      int cyc;
      logic [31:0] e;
      chk({name, "_in_ready_before"}, in_ready, 1);
      op_a = a; op_b = b; funct = f; in_valid = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      op_a = $urandom; op_b = $urandom;
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk({name, "_latency"}, cyc, 34);
      if (out_valid) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
         chk({name, "_result"}, result, e);
         chk({name, "_in_ready_done"}, in_ready, 0);
         chk({name, "_busy_done"}, busy, 1);
         @(negedge clk);
         chk({name, "_idle_at_35"}, in_ready, 1);
         chk({name, "_out_valid_low"}, out_valid, 0);
      end
   endtask

   initial begin
      vec_t vt[$];
      logic [31:0] held, a, b;
      logic [1:0]  f;
      int cyc;

      rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; funct = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_result", result, 0);
      rst = 1'b0;
      @(negedge clk);

      vt.push_back('{32'h00000007, 32'h00000006, 2'b00, 32'h0000002A});
      vt.push_back('{32'h80000000, 32'h80000000, 2'b01, 32'h40000000});
      vt.push_back('{32'hFFFFFFFF, 32'h00000003, 2'b00, 32'hFFFFFFFD});
      vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hFFFFFFFF});
      vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'hFFFFFFFE});
      vt.push_back('{32'hFFFFFFFF, 32'h00000001, 2'b01, 32'hFFFFFFFF});
      vt.push_back('{32'h00000000, 32'h12345678, 2'b01, 32'h00000000});
      vt.push_back('{32'h80000000, 32'hFFFFFFFF, 2'b00, 32'h80000000});
      vt.push_back('{32'h80000000, 32'hFFFFFFFF, 2'b01, 32'h00000000});
      vt.push_back('{32'h80000000, 32'h00000002, 2'b11, 32'h00000001});
      vt.push_back('{32'h7FFFFFFF, 32'h7FFFFFFF, 2'b01, 32'h3FFFFFFF});
      vt.push_back('{32'h80000000, 32'hFFFFFFFF, 2'b10, 32'h80000000});
      foreach (vt[i]) run_op(vt[i].a, vt[i].b, vt[i].f, vt[i].exp, $sformatf("vec%0d", i));

      // Backpressure: result must hold and in_valid pulses must be ignored.
      out_ready = 1'b0;
      op_a = 32'h00001234; op_b = 32'h00000010; funct = 2'b00; in_valid = 1'b1;
      exp_q.push_back(32'h00012340);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("bp_latency", cyc, 34);
      held = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      for (int k = 0; k < 10; k++) begin
         in_valid = k[0];
         op_a = $urandom; op_b = $urandom; funct = 2'b11;
         @(negedge clk);
         chk($sformatf("bp_result_%0d", k), result, held);
         chk($sformatf("bp_in_ready_%0d", k), in_ready, 0);
         chk($sformatf("bp_out_valid_%0d", k), out_valid, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_idle", in_ready, 1);
      chk("bp_release_out_valid", out_valid, 0);
      repeat (2) @(negedge clk);
      chk("bp_no_ghost_op", busy, 0);
      chk("bp_result_holds_idle", result, held);

      // Reset in the middle of RUN drops the op.
      op_a = 32'h0000FFFF; op_b = 32'h0000FFFF; funct = 2'b00; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (14) @(negedge clk);
      chk("rst_mid_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_result", result, 0);
      chk("rst_mid_busy_low", busy, 0);
      rst = 1'b0;
      @(negedge clk);
      run_op(32'd3, 32'd5, 2'b00, 32'h0000000F, "after_rst");

      // Back-to-back random ops against the 64-bit reference.
      for (int n = 0; n < 100; n++) begin
         a = $urandom; b = $urandom; f = 2'($urandom_range(0, 3));
         if (n % 10 == 0) a = 32'h80000000;
         if (n % 13 == 0) b = 32'hFFFFFFFF;
         run_op(a, b, f, ref_mul(a, b, f), $sformatf("rnd%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog");
   end
endmodule
